// File: rtl/invaders_march_controller.sv
// Invader formation march sequencer: counts frames, scans a snapshot of the
// alive mask for the occupied column span, then steps sideways or descends.
module invaders_march_controller #(
    parameter int X_START    = 100,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 799,
    parameter int STEP_X     = 4,
    parameter int COL_WIDTH  = 32,
    parameter int MIN_PERIOD = 2
) (
    input  logic        clk_36MHz,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [19:0] invaders_array,
    input  logic [1:0]  gameplay,
    output logic [9:0]  invaders_x,
    output logic [3:0]  invaders_line,
    output logic        direction,
    output logic        step_pulse,
    output logic        anim_frame
);
    typedef enum logic [1:0] {S_WAIT, S_SCAN, S_DECIDE} state_t;

    state_t      r_state;
    logic [5:0]  r_tick_cnt;
    logic [19:0] r_snap;
    logic [3:0]  r_col;
    logic        r_found;
    logic [3:0]  r_lmin;
    logic [3:0]  r_rmax;
    logic [9:0]  r_x;
    logic [3:0]  r_line;
    logic        r_dir;
    logic        r_pulse;
    logic        r_anim;

    logic [4:0]  w_alive;
    logic [5:0]  w_period;
    logic        w_fire;
    logic        w_occ;
    logic [10:0] w_left;
    logic [10:0] w_right;
    logic        w_descend;

    always_comb begin
        w_alive = '0;
        for (int i = 0; i < 20; i++) w_alive = w_alive + 5'(invaders_array[i]);
    end

    assign w_period = 6'(MIN_PERIOD) + {w_alive, 1'b0};
    // >= rather than == so a period that shrank below the count fires next tick
    assign w_fire   = (r_tick_cnt >= w_period - 6'd1);
    assign w_occ    = r_snap[5'(r_col)] | r_snap[5'(r_col) + 5'd10];

    assign w_left    = {1'b0, r_x} + 11'(r_lmin) * 11'(COL_WIDTH);
    assign w_right   = {1'b0, r_x} + (11'(r_rmax) + 11'd1) * 11'(COL_WIDTH) - 11'd1;
    assign w_descend = r_dir ? (w_right + 11'(STEP_X) > 11'(X_MAX))
                             : (w_left < 11'(X_MIN + STEP_X));

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_tick_cnt <= '0;
            r_snap     <= '0;
            r_col      <= '0;
            r_found    <= 1'b0;
            r_lmin     <= '0;
            r_rmax     <= '0;
            r_x        <= 10'(X_START);
            r_line     <= '0;
            r_dir      <= 1'b1;
            r_pulse    <= 1'b0;
            r_anim     <= 1'b0;
        end else begin
            // step_pulse is a strobe; it never stretches across a freeze
            r_pulse <= 1'b0;
            if (gameplay == 2'b00) begin
                case (r_state)
                    S_WAIT: begin
                        if (frame_tick) begin
                            if (w_fire) begin
                                r_tick_cnt <= '0;
                                r_snap     <= invaders_array;
                                r_col      <= '0;
                                r_found    <= 1'b0;
                                r_lmin     <= '0;
                                r_rmax     <= '0;
                                r_state    <= S_SCAN;
                            end else begin
                                r_tick_cnt <= r_tick_cnt + 6'd1;
                            end
                        end
                    end
                    S_SCAN: begin
                        if (w_occ) begin
                            if (!r_found) begin
                                r_lmin  <= r_col;
                                r_found <= 1'b1;
                            end
                            r_rmax <= r_col;
                        end
                        if (r_col == 4'd9) r_state <= S_DECIDE;
                        else               r_col   <= r_col + 4'd1;
                    end
                    S_DECIDE: begin
                        r_state <= S_WAIT;
                        if (r_found) begin
                            r_pulse <= 1'b1;
                            r_anim  <= ~r_anim;
                            if (w_descend) begin
                                if (r_line != 4'd15) r_line <= r_line + 4'd1;
                                r_dir <= ~r_dir;
                            end else if (r_dir) begin
                                r_x <= r_x + 10'(STEP_X);
                            end else begin
                                r_x <= r_x - 10'(STEP_X);
                            end
                        end
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

    assign invaders_x    = r_x;
    assign invaders_line = r_line;
    assign direction     = r_dir;
    assign step_pulse    = r_pulse;
    assign anim_frame    = r_anim;
endmodule

// File: tb/tb_invaders_march_controller.sv
// Bench for invaders_march_controller: table of step vectors plus hand-written
// corner sequences, with a scoreboard of expected post-step outputs.
module tb_invaders_march_controller;
    logic        clk_36MHz = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [19:0] invaders_array;
    logic [1:0]  gameplay;
    logic [9:0]  invaders_x;
    logic [3:0]  invaders_line;
    logic        direction;
    logic        step_pulse;
    logic        anim_frame;

    always #14 clk_36MHz = ~clk_36MHz;

    invaders_march_controller dut (
        .clk_36MHz      (clk_36MHz),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .invaders_array (invaders_array),
        .gameplay       (gameplay),
        .invaders_x     (invaders_x),
        .invaders_line  (invaders_line),
        .direction      (direction),
        .step_pulse     (step_pulse),
        .anim_frame     (anim_frame)
    );

    typedef struct {
        logic [9:0] x;
        logic [3:0] line;
        logic       dir;
        logic       anim;
    } exp_t;

    typedef struct {
        logic [19:0] mask;
        int          period;
    } vec_t;

    exp_t sb[$];
    vec_t tbl [0:4];
    int   checks = 0;
    int   errors = 0;

    logic [9:0] m_x;
    logic [3:0] m_line;
    logic       m_dir;
    logic       m_anim;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 10'd100; m_line = 4'd0; m_dir = 1'b1; m_anim = 1'b0;
    endtask

    // Reference decision from the column span of mask m; pushes expected outputs.
    task automatic model_step(input logic [19:0] m, output bit pulse);
        int lmin, rmax, le, re;
        bit desc;
        lmin = -1; rmax = -1; pulse = 1'b0;
        for (int c = 0; c < 10; c++)
            if (m[c] || m[c+10]) begin
                if (lmin < 0) lmin = c;
                rmax = c;
            end
        if (lmin >= 0) begin
            le = int'(m_x) + lmin * 32;
            re = int'(m_x) + (rmax + 1) * 32 - 1;
            desc = m_dir ? (re + 4 > 799) : (le < 4);
            if (desc) begin
                if (m_line != 4'd15) m_line = m_line + 4'd1;
                m_dir = ~m_dir;
            end else begin
                m_x = m_dir ? m_x + 10'd4 : m_x - 10'd4;
            end
            m_anim = ~m_anim;
            sb.push_back('{m_x, m_line, m_dir, m_anim});
            pulse = 1'b1;
        end
    endtask

    always @(negedge clk_36MHz) begin : mon
        exp_t e;
        if (reset === 1'b0 && step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_step_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_x",    32'(invaders_x),    32'(e.x));
                chk("sb_line", 32'(invaders_line), 32'(e.line));
                chk("sb_dir",  32'(direction),     32'(e.dir));
                chk("sb_anim", 32'(anim_frame),    32'(e.anim));
            end
        end
    end

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk_36MHz);
        frame_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk_36MHz);
        end
    endtask

    // Qualifying tick; optionally rewrite the mask while the DUT is scanning.
    task automatic fire(input logic [19:0] m, input bit chg, input logic [19:0] m2);
        bit p;
        invaders_array = m;
        model_step(m, p);
        tick();
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk_36MHz);
            if (chg && k == 3) invaders_array = m2;
            if (k == 11) chk("pulse_before_T12", 32'(step_pulse), 32'd0);
            if (k == 12) chk("pulse_at_T12", 32'(step_pulse), 32'(p));
            if (k == 13) chk("pulse_T13", 32'(step_pulse), 32'd0);
        end
    endtask

    task automatic step(input logic [19:0] m, input int period);
        invaders_array = m;
        run_ticks(period - 1);
        fire(m, 1'b0, 20'h0);
    endtask

    task automatic chk_frozen(input string tag);
        chk({tag, "_x"},    32'(invaders_x),    32'(m_x));
        chk({tag, "_line"}, 32'(invaders_line), 32'(m_line));
        chk({tag, "_dir"},  32'(direction),     32'(m_dir));
        chk({tag, "_anim"}, 32'(anim_frame),    32'(m_anim));
    endtask

    initial begin
        int         n;
        bit         done;
        logic [3:0] pl;
        logic       pd;

        tbl[0] = '{20'hFFFFF, 42};
        tbl[1] = '{20'h00001, 4};
        tbl[2] = '{20'h00401, 6};
        tbl[3] = '{20'h003FF, 22};
        tbl[4] = '{20'h80000, 4};

        // Reset wins over a simultaneous frame_tick.
        reset = 1'b1; frame_tick = 1'b1; invaders_array = 20'hFFFFF; gameplay = 2'b00;
        repeat (3) @(negedge clk_36MHz);
        frame_tick = 1'b0;
        chk("rst_x", 32'(invaders_x), 32'd100);
        chk("rst_line", 32'(invaders_line), 32'd0);
        chk("rst_dir", 32'(direction), 32'd1);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_anim", 32'(anim_frame), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk_36MHz);

        for (int i = 0; i < 5; i++) begin
            step(tbl[i].mask, tbl[i].period);
            if (i == 0) begin
                chk("first_step_x", 32'(invaders_x), 32'd104);
                chk("first_step_anim", 32'(anim_frame), 32'd1);
                chk("first_step_line", 32'(invaders_line), 32'd0);
            end
        end

        // Full formation to the right edge. At x=476 the right edge is 795 and
        // 795+4 is not beyond 799, so the descend comes from x=480.
        n = 0;
        while (m_line == 4'd0 && n < 200) begin
            step(20'hFFFFF, 42);
            n++;
        end
        chk("right_desc_line", 32'(invaders_line), 32'd1);
        chk("right_desc_dir", 32'(direction), 32'd0);
        chk("right_desc_x", 32'(invaders_x), 32'd480);
        step(20'hFFFFF, 42);
        chk("after_desc_x", 32'(invaders_x), 32'd476);

        // Single invader marches left to x=0.
        n = 0;
        while (!(m_dir == 1'b0 && m_x == 10'd0) && n < 400) begin
            step(20'h00001, 4);
            n++;
        end
        chk("left_reach_x", 32'(invaders_x), 32'd0);

        // Snapshot (column 0) forces the descend even though the live mask is
        // changed mid-scan to columns 8..9, which alone would allow a step.
        invaders_array = 20'h00001;
        run_ticks(3);
        fire(20'h00001, 1'b1, 20'h00300);
        chk("left_desc_line", 32'(invaders_line), 32'd2);
        chk("left_desc_dir", 32'(direction), 32'd1);
        chk("left_desc_x", 32'(invaders_x), 32'd0);
        // New mask has two alive: period 6, an early step at tick 4 would be caught.
        step(20'h00300, 6);

        // Freeze mid-count, then finish the remaining ticks of the same count.
        run_ticks(2);
        gameplay = 2'b10;
        run_ticks(100);
        chk_frozen("frz_over");
        gameplay = 2'b01;
        run_ticks(3);
        chk_frozen("frz_win");
        gameplay = 2'b00;
        run_ticks(3);
        fire(20'h00300, 1'b0, 20'h0);

        // Empty formation: ticks spaced so none land in scan; never a step.
        invaders_array = 20'h0;
        for (int i = 0; i < 50; i++) begin
            tick();
            repeat (12) @(negedge clk_36MHz);
        end
        chk_frozen("empty");

        // March columns 0 and 9 until a descend happens at line 15.
        n = 0; done = 1'b0;
        while (!done && n < 2500) begin
            pl = m_line; pd = m_dir;
            step(20'h00201, 6);
            if (pl == 4'd15 && pd != m_dir) done = 1'b1;
            n++;
        end
        chk("sat_descend_seen", 32'(done), 32'd1);
        chk("sat_line", 32'(invaders_line), 32'd15);

        // Reset in the middle of a scan.
        invaders_array = 20'hFFFFF;
        run_ticks(41);
        tick();
        repeat (4) @(negedge clk_36MHz);
        reset = 1'b1;
        @(negedge clk_36MHz);
        chk("midscan_rst_x", 32'(invaders_x), 32'd100);
        chk("midscan_rst_line", 32'(invaders_line), 32'd0);
        chk("midscan_rst_dir", 32'(direction), 32'd1);
        chk("midscan_rst_pulse", 32'(step_pulse), 32'd0);
        chk("midscan_rst_anim", 32'(anim_frame), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk_36MHz);
        step(20'hFFFFF, 42);
        chk("post_rst_x", 32'(invaders_x), 32'd104);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
